// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: hunts for SYNC_WORD, then assembles WIDTH-bit words MSB first.
// Zero added latency (word valid on the edge of its last bit); one-entry buffer, full buffer drops words into sticky overflow.
module serial_word_deserializer #(
  parameter int               WIDTH     = 16,
  parameter int               LOGWIDTH  = 4,
  parameter logic [WIDTH-1:0] SYNC_WORD = 16'hB38F
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             data_i,
  input  logic             bit_valid_i,
  input  logic             relock_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             locked_o,
  output logic             overflow_o
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [LOGWIDTH:0] CNT_LAST = (LOGWIDTH+1)'(WIDTH - 1);
  localparam logic [LOGWIDTH:0] CNT_FULL = (LOGWIDTH+1)'(WIDTH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [LOGWIDTH:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  cand;
  logic              drain;

  assign cand  = {sr_q[WIDTH-2:0], data_i};
  assign drain = valid_q && ready_i;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = valid_q && !drain;
    overflow_d = overflow_q;

    if (bit_valid_i) begin
      sr_d = cand;
    end

    if (relock_i) begin
      // The bit arriving with the relock pulse is already the first fill bit.
      state_d    = HUNT;
      cnt_d      = {{LOGWIDTH{1'b0}}, bit_valid_i};
      overflow_d = 1'b0;
    end else if (bit_valid_i) begin
      case (state_q)
        HUNT: begin
          if (cnt_q >= CNT_LAST && cand == SYNC_WORD) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else if (cnt_q < CNT_FULL) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            // A completed word equal to the sync word is a re-sync marker, not payload.
            if (cand != SYNC_WORD) begin
              if (!valid_q || drain) begin
                data_d  = cand;
                valid_d = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_ni) begin
    if (reset_ni) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign locked_o   = (state_q == LOCKED);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer: alignment, gapped input, backpressure, re-sync, relock and reset.
module tb_serial_word_deserializer;

  localparam logic [15:0] SYNC = 16'hB38F;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        data_i = 1'b0;
  logic        bit_valid_i = 1'b0;
  logic        relock_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] data_o;
  logic        valid_o;
  logic        locked_o;
  logic        overflow_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          base = 0;
  int          lock_edge = -1;
  logic [15:0] wq[$];
  int          eq[$];
  logic        pv, pl, pr;

  serial_word_deserializer #(.WIDTH(16), .LOGWIDTH(4), .SYNC_WORD(16'hB38F)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .bit_valid_i(bit_valid_i),
    .relock_i(relock_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .locked_o(locked_o), .overflow_o(overflow_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Records every newly loaded word and the edge on which locked_o rises.
  initial begin
    pv = 1'b0;
    pl = 1'b0;
    forever begin
      @(posedge clk_i);
      pr = ready_i;
      #1;
      edge_n++;
      if (valid_o && (!pv || pr)) begin
        wq.push_back(data_o);
        eq.push_back(edge_n - base);
      end
      if (locked_o && !pl) lock_edge = edge_n - base;
      pv = valid_o;
      pl = locked_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    reset_ni    = 1'b1;
    bit_valid_i = 1'b0;
    relock_i    = 1'b0;
    data_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    reset_ni = 1'b0;
    wq.delete();
    eq.delete();
    base      = edge_n;
    lock_edge = -1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    data_i      = b;
    bit_valid_i = 1'b1;
    tick();
    bit_valid_i = 1'b0;
    if (gap) begin
      data_i = ~b;
      tick();
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (data_o !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h expected 0000", data_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b expected 0", locked_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
  endtask

  task automatic test_alignment(input bit gap);
    int exp_lock, exp_e0, exp_e1;
    exp_lock = gap ? 41 : 21;
    exp_e0   = gap ? 73 : 37;
    exp_e1   = gap ? 105 : 53;
    do_reset();
    ready_i = 1'b1;
    send_bit(1'b1, gap); send_bit(1'b0, gap); send_bit(1'b1, gap);
    send_bit(1'b1, gap); send_bit(1'b0, gap);
    send_word(SYNC, gap);
    send_word(16'h1234, gap);
    send_word(16'hBEEF, gap);
    tick();
    n_vec++; if (lock_edge != exp_lock) begin n_err++; $display("FAIL align_lock_edge gap=%0d: got %0d expected %0d", gap, lock_edge, exp_lock); end
    n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL align_word_count gap=%0d: got %0d expected 2", gap, wq.size()); end
    if (wq.size() >= 2) begin
      n_vec++; if (wq[0] !== 16'h1234 || eq[0] != exp_e0) begin n_err++; $display("FAIL align_word0 gap=%0d: got %h@%0d expected 1234@%0d", gap, wq[0], eq[0], exp_e0); end
      n_vec++; if (wq[1] !== 16'hBEEF || eq[1] != exp_e1) begin n_err++; $display("FAIL align_word1 gap=%0d: got %h@%0d expected beef@%0d", gap, wq[1], eq[1], exp_e1); end
    end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL align_drained gap=%0d: got valid %b expected 0", gap, valid_o); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    ready_i = 1'b0;
    send_word(SYNC, 1'b0);
    send_word(16'h1111, 1'b0);
    for (int i = 15; i >= 9; i--) send_bit(16'hABCD >> i, 1'b0);
    n_vec++; if (valid_o !== 1'b1 || locked_o !== 1'b1) begin n_err++; $display("FAIL midword_pre: got valid %b locked %b expected 1 1", valid_o, locked_o); end
    reset_ni = 1'b1;
    #1;
    n_vec++; if (data_o !== 16'h0000) begin n_err++; $display("FAIL midword_rst_data: got %h expected 0000", data_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL midword_rst_valid: got %b expected 0", valid_o); end
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL midword_rst_locked: got %b expected 0", locked_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL midword_rst_overflow: got %b expected 0", overflow_o); end
    do_reset();
    ready_i = 1'b1;
    send_word(SYNC, 1'b0);
    send_word(16'h1234, 1'b0);
    tick();
    tick();
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL midword_count: got %0d expected 1", wq.size()); end
    if (wq.size() >= 1) begin
      n_vec++; if (wq[0] !== 16'h1234) begin n_err++; $display("FAIL midword_word: got %h expected 1234", wq[0]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_i = 1'b0;
    send_word(SYNC, 1'b0);
    send_word(16'h0001, 1'b0);
    n_vec++; if (valid_o !== 1'b1 || data_o !== 16'h0001 || overflow_o !== 1'b0) begin n_err++; $display("FAIL bp_first: got v%b %h ovf%b expected v1 0001 ovf0", valid_o, data_o, overflow_o); end
    send_word(16'h0002, 1'b0);
    n_vec++; if (overflow_o !== 1'b1 || data_o !== 16'h0001) begin n_err++; $display("FAIL bp_second: got ovf%b %h expected ovf1 0001", overflow_o, data_o); end
    send_word(16'h0003, 1'b0);
    n_vec++; if (data_o !== 16'h0001 || valid_o !== 1'b1 || overflow_o !== 1'b1) begin n_err++; $display("FAIL bp_third: got v%b %h ovf%b expected v1 0001 ovf1", valid_o, data_o, overflow_o); end
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL bp_count: got %0d expected 1", wq.size()); end
    relock_i = 1'b1;
    tick();
    relock_i = 1'b0;
    n_vec++; if (overflow_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 16'h0001) begin n_err++; $display("FAIL bp_relock: got ovf%b v%b %h expected ovf0 v1 0001", overflow_o, valid_o, data_o); end
    ready_i = 1'b1;
    tick();
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_accept: got valid %b expected 0", valid_o); end
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL bp_final_count: got %0d expected 1", wq.size()); end
  endtask

  task automatic test_resync_relock();
    do_reset();
    ready_i = 1'b1;
    send_word(SYNC, 1'b0);
    send_word(16'hAAAA, 1'b0);
    send_word(SYNC, 1'b0);
    send_word(16'h5555, 1'b0);
    tick();
    n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL resync_count: got %0d expected 2", wq.size()); end
    if (wq.size() >= 2) begin
      n_vec++; if (wq[0] !== 16'hAAAA || wq[1] !== 16'h5555) begin n_err++; $display("FAIL resync_words: got %h %h expected aaaa 5555", wq[0], wq[1]); end
    end
    wq.delete();
    eq.delete();
    for (int i = 15; i >= 8; i--) send_bit(16'h9999 >> i, 1'b0);
    relock_i = 1'b1;
    tick();
    relock_i  = 1'b0;
    lock_edge = -1;
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL relock_drop: got locked %b expected 0", locked_o); end
    // The bit before the relock was 1, so sync[14:0] now completes a sync pattern in sr.
    for (int i = 14; i >= 0; i--) send_bit(SYNC[i], 1'b0);
    send_bit(1'b0, 1'b0);
    n_vec++; if (lock_edge != -1 || locked_o !== 1'b0) begin n_err++; $display("FAIL relock_fill_guard: got lock_edge %0d locked %b expected -1 0", lock_edge, locked_o); end
    n_vec++; if (wq.size() != 0) begin n_err++; $display("FAIL relock_partial: got %0d words expected 0", wq.size()); end
    relock_i    = 1'b1;
    data_i      = 1'b1;
    bit_valid_i = 1'b1;
    tick();
    relock_i    = 1'b0;
    bit_valid_i = 1'b0;
    for (int i = 14; i >= 1; i--) send_bit(SYNC[i], 1'b0);
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL relock_bit1_early: got locked %b expected 0", locked_o); end
    send_bit(SYNC[0], 1'b0);
    n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL relock_bit1_lock: got locked %b expected 1", locked_o); end
  endtask

  task automatic test_relock_completion();
    do_reset();
    ready_i = 1'b0;
    send_word(SYNC, 1'b0);
    send_word(16'h1111, 1'b0);
    for (int i = 15; i >= 1; i--) send_bit(16'h7777 >> i, 1'b0);
    data_i      = 1'b1;
    bit_valid_i = 1'b1;
    relock_i    = 1'b1;
    tick();
    relock_i    = 1'b0;
    bit_valid_i = 1'b0;
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL rc_overflow: got %b expected 0", overflow_o); end
    n_vec++; if (data_o !== 16'h1111 || valid_o !== 1'b1) begin n_err++; $display("FAIL rc_buffer: got v%b %h expected v1 1111", valid_o, data_o); end
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL rc_locked: got %b expected 0", locked_o); end
    ready_i = 1'b1;
    tick();
    send_word(16'h7777, 1'b0);
    tick();
    n_vec++; if (wq.size() != 1 || valid_o !== 1'b0 || locked_o !== 1'b0) begin n_err++; $display("FAIL rc_hunt: got %0d words v%b locked %b expected 1 v0 locked 0", wq.size(), valid_o, locked_o); end
  endtask

  initial begin
    test_reset();
    test_alignment(1'b0);
    test_alignment(1'b1);
    test_reset_midword();
    test_backpressure();
    test_resync_relock();
    test_relock_completion();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Receive-side counterpart of the mixed serializer. Takes the serial bit stream, hunts for a sync word to find word boundaries, and reassembles `WIDTH`-bit parallel words. Completed words go to a one-entry output buffer with a valid/ready handshake. Runs entirely in the fast bit-clock domain, after the link's fast output register.

## Interface
- `WIDTH`, default 16: word width; matches the serializer's parallel input width.
- `LOGWIDTH`, default 4: bit-counter width; equals `$clog2(WIDTH)`.
- `SYNC_WORD`, default `16'hB38F`: alignment marker; `WIDTH` bits wide, MSB first on the line.

Ports:
- `clk_i`, in, 1: bit clock. The only clock; all logic samples on its rising edge.
- `reset_ni`, in, 1: asynchronous, active-high reset (high = reset, despite the name).
- `data_i`, in, 1: serial data bit.
- `bit_valid_i`, in, 1: `data_i` is a valid bit this cycle.
- `relock_i`, in, 1: single-cycle pulse; drop alignment and return to HUNT.
- `data_o`, out, `WIDTH`: reassembled word; the first received bit is the MSB.
- `valid_o`, out, 1: `data_o` holds an undelivered word.
- `ready_i`, in, 1: consumer accepts `data_o` when `valid_o && ready_i`.
- `locked_o`, out, 1: word alignment established.
- `overflow_o`, out, 1: sticky; a completed word was dropped because the buffer was full.

## Operation
- Shift register `sr[WIDTH-1:0]` shifts left on every `bit_valid_i`, inserting `data_i` at the LSB. Bits present while `bit_valid_i=0` are ignored.
- Candidate word `cand = {sr[WIDTH-2:0], data_i}`.
- Counter `cnt[LOGWIDTH:0]` counts valid bits; its meaning depends on state.
- HUNT state:
  - `cnt` counts fill, saturating at `WIDTH`.
  - Sync compare is enabled only when `cnt >= WIDTH-1` and `bit_valid_i=1`, so no match is possible on reset/HUNT-entry zeros.
  - `cand == SYNC_WORD` -> LOCKED, `cnt <= 0`, `locked_o <= 1`.
- LOCKED state: `cnt` counts bit position 0..`WIDTH-1`. On a valid bit with `cnt == WIDTH-1`, the word is complete and `cnt <= 0`:
  - `cand == SYNC_WORD`: periodic re-sync marker; discarded, no output, stay LOCKED.
  - otherwise, if the buffer is empty or being drained this cycle (`valid_o && ready_i`): `data_o <= cand`, `valid_o <= 1`.
  - otherwise: word dropped, `overflow_o <= 1`, buffer contents unchanged.
- Handshake:
  - With no new load, `valid_o && ready_i` clears `valid_o`.
  - `data_o` is stable while `valid_o=1 && ready_i=0`.
  - `valid_o` never drops without acceptance, except on reset.
- `relock_i` (any state):
  - -> HUNT, `cnt <= 0`, `locked_o <= 0`, `overflow_o <= 0`; any partial word is discarded.
  - `sr` is not cleared; the fill counter alone prevents false matches.
  - The output buffer is untouched: a held word is still delivered.
  - If `relock_i` coincides with word completion, `relock_i` wins and the word is neither loaded nor counted as overflow.
  - The `bit_valid_i` bit arriving in the `relock_i` cycle is shifted in and counts as fill bit 1.
- Reset: state HUNT, `sr=0`, `cnt=0`, `data_o=0`, `valid_o=0`, `locked_o=0`, `overflow_o=0`.

## Timing
- Sync detection: the last sync bit is sampled at edge N; `locked_o` is 1 from edge N. The next valid bit is data bit 0 (the MSB).
- Word latency: the last data bit is sampled at edge N; `data_o`/`valid_o` update at edge N. No further pipeline.
- Back-to-back words with `ready_i=1` held: one word every `WIDTH` valid bits, no bubbles. Load and drain in the same edge are legal.
- Throughput limit: the consumer must accept within `WIDTH` valid-bit times or the next word overflows.
- Reset is asynchronous: outputs go to their reset values immediately on `reset_ni` rising, independent of `clk_i`.

## Test plan
- Reset mid-word:
  - Stimulus: assert `reset_ni` while LOCKED at `cnt=7` with `valid_o=1`.
  - Required: all outputs 0 immediately.
  - After release, `0xB38F` followed by `0x1234` gives `data_o=0x1234` exactly one time.
- Alignment:
  - Stimulus: 5 junk bits `10110`, then `0xB38F`, then `0x1234`, then `0xBEEF`, with `ready_i=1` and `bit_valid_i` always 1.
  - Required: `locked_o` rises on the 21st edge; `valid_o` pulses with `0x1234` at edge 37 and `0xBEEF` at edge 53.
- Gapped input:
  - Stimulus: same stream as the alignment test, with `bit_valid_i` toggling 1/0.
  - Required: identical words; each `valid_o` edge is delayed to the edge of the word's last valid bit.
- Backpressure and overflow:
  - Stimulus: `ready_i=0`; send sync, then `0x0001`, `0x0002`, `0x0003`.
  - Required: `data_o` holds `0x0001`; `overflow_o` sets at the end of `0x0002`; `0x0003` is also dropped.
  - Then raise `ready_i`: `0x0001` is accepted and `valid_o` falls.
- Re-sync marker and relock:
  - Stimulus 1: send sync, `0xAAAA`, `0xB38F`, `0x5555`. Required: outputs `0xAAAA` then `0x5555` only.
  - Stimulus 2: pulse `relock_i` at `cnt=8` of a word. Required: `locked_o=0` next edge and the partial word is never output.
  - Stimulus 3: after relock, the first 15 valid bits equal the sync prefix. Required: no lock until the fill counter reaches `WIDTH-1` bits.
- Relock on word completion:
  - Stimulus: `relock_i` in the same cycle as the last bit of `0x7777`.
  - Required: `0x7777` is not loaded, `overflow_o` stays 0, state is HUNT.
